// File: rtl/pheap_level.sv
// One level of a pipelined max-heap: holds 2^(LEVEL-1) entries and pushes requests to the level below.
// Optional PHEAP_LEVEL_OCC_EN adds an 'occ' output counting active entries at this level.
module pheap_level #(
    parameter int LEVELS = 4,
    parameter int LEVEL  = 2,
    parameter int KW     = 16,
    parameter int VW     = 16,
    localparam int CW    = LEVELS,
    localparam int AW    = LEVEL - 1,
    localparam int KVW   = KW + VW,
    localparam int EW    = KW + VW + CW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_start,
    input  logic [1:0]     up_op,
    input  logic [KVW-1:0] up_kv,
    input  logic [AW-1:0]  up_addr,
    input  logic [AW-1:0]  up_raddr,
    output logic [EW-1:0]  up_rdL,
    output logic [EW-1:0]  up_rdR,
    output logic [AW:0]    dn_raddr,
    input  logic [EW-1:0]  dn_rdL,
    input  logic [EW-1:0]  dn_rdR,
    output logic           dn_start,
    output logic [1:0]     dn_op,
    output logic [KVW-1:0] dn_kv,
    output logic [AW:0]    dn_addr,
    output logic [1:0]     done,
    output logic           busy,
    output logic           ovf
`ifdef PHEAP_LEVEL_OCC_EN
    ,
    output logic [AW+1:0]  occ
`endif
);
    // state | meaning
    // IDLE  | waiting for a request from the level above
    // EXEC  | one cycle: update own entry, optionally issue request below
    typedef enum logic {S_IDLE, S_EXEC} state_t;

    localparam logic [1:0] OP_LEQ = 2'b00, OP_DEQ = 2'b01, OP_ENQ_DEQ = 2'b10, OP_NOP = 2'b11;
    localparam logic [1:0] D_DONE = 2'b00, D_WAIT = 2'b01, D_NEXT = 2'b10;
    localparam logic [CW-1:0] RST_CAP = CW'((2 ** (LEVELS - LEVEL + 1)) - 1);
    localparam logic [EW-1:0] RST_ENTRY = {{KVW{1'b0}}, RST_CAP, 1'b0};

    state_t         r_state;
    logic [1:0]     r_op;
    logic [KVW-1:0] r_kv;
    logic [AW-1:0]  r_addr;
    logic [EW-1:0]  r_mem [2**AW];
    logic           r_dn_start, r_busy, r_ovf;
    logic [1:0]     r_dn_op, r_done;
    logic [KVW-1:0] r_dn_kv;
    logic [AW:0]    r_dn_addr;

    logic [AW-1:0]  w_pair;
    logic [EW-1:0]  w_e;
    logic [KVW-1:0] w_e_kv, w_cl_kv, w_cr_kv, w_ch_kv, w_hi_kv, w_lo_kv;
    logic [KW-1:0]  w_e_key, w_in_key, w_cl_key, w_cr_key, w_ch_key;
    logic [CW-1:0]  w_e_cap, w_cl_cap, w_cr_cap, w_cap_dec, w_cap_inc;
    logic           w_e_act, w_cl_act, w_cr_act, w_any_act, w_sel_r;
    logic           w_in_gt_e, w_leq_r, w_full, w_enq_keep;

    assign w_pair   = up_raddr & ~AW'(1);
    assign up_rdL   = r_mem[w_pair];
    assign up_rdR   = r_mem[w_pair | AW'(1)];
    assign dn_raddr = {r_addr, 1'b0};

    assign w_e      = r_mem[r_addr];
    assign w_e_kv   = w_e[EW-1 -: KVW];
    assign w_e_key  = w_e[EW-1 -: KW];
    assign w_e_cap  = w_e[CW:1];
    assign w_e_act  = w_e[0];
    assign w_in_key = r_kv[KVW-1 -: KW];

    assign w_cl_kv  = dn_rdL[EW-1 -: KVW];
    assign w_cl_key = dn_rdL[EW-1 -: KW];
    assign w_cl_cap = dn_rdL[CW:1];
    assign w_cl_act = dn_rdL[0];
    assign w_cr_kv  = dn_rdR[EW-1 -: KVW];
    assign w_cr_key = dn_rdR[EW-1 -: KW];
    assign w_cr_cap = dn_rdR[CW:1];
    assign w_cr_act = dn_rdR[0];

    // Larger active child, left wins ties; used by both DEQ and ENQ_DEQ.
    assign w_any_act  = w_cl_act | w_cr_act;
    assign w_sel_r    = w_cr_act & (~w_cl_act | (w_cr_key > w_cl_key));
    assign w_ch_kv    = w_sel_r ? w_cr_kv : w_cl_kv;
    assign w_ch_key   = w_sel_r ? w_cr_key : w_cl_key;
    assign w_enq_keep = ~w_any_act | (w_in_key > w_ch_key);

    assign w_in_gt_e = w_in_key > w_e_key;
    assign w_hi_kv   = w_in_gt_e ? r_kv : w_e_kv;
    assign w_lo_kv   = w_in_gt_e ? w_e_kv : r_kv;
    assign w_leq_r   = w_cr_cap > w_cl_cap;
    assign w_full    = (w_cl_cap == '0) && (w_cr_cap == '0);
    assign w_cap_dec = (w_e_cap == '0) ? '0 : w_e_cap - CW'(1);
    assign w_cap_inc = w_e_cap + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_LEQ;
            r_kv       <= '0;
            r_addr     <= '0;
            r_dn_start <= 1'b0;
            r_dn_op    <= '0;
            r_dn_kv    <= '0;
            r_dn_addr  <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= D_DONE;
            for (int i = 0; i < 2**AW; i++) r_mem[i] <= RST_ENTRY;
        end else begin
            r_dn_start <= 1'b0;
            r_dn_op    <= '0;
            r_dn_kv    <= '0;
            r_dn_addr  <= '0;
            r_ovf      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (up_start && up_op != OP_NOP) begin
                        r_state <= S_EXEC;
                        r_busy  <= 1'b1;
                        r_op    <= up_op;
                        r_kv    <= up_kv;
                        r_addr  <= up_addr;
                        r_done  <= D_WAIT;
                    end else begin
                        r_done  <= D_DONE;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= D_DONE;
                    case (r_op)
                        OP_LEQ: begin
                            if (!w_e_act) begin
                                r_mem[r_addr] <= {r_kv, w_cap_dec, 1'b1};
                            end else if (w_full) begin
                                r_mem[r_addr] <= {w_hi_kv, w_e_cap, 1'b1};
                                r_ovf         <= 1'b1;
                            end else begin
                                r_mem[r_addr] <= {w_hi_kv, w_cap_dec, 1'b1};
                                r_dn_start    <= 1'b1;
                                r_dn_op       <= OP_LEQ;
                                r_dn_kv       <= w_lo_kv;
                                r_dn_addr     <= {r_addr, w_leq_r};
                                r_done        <= D_NEXT;
                            end
                        end
                        OP_DEQ: begin
                            if (!w_any_act) begin
                                r_mem[r_addr] <= {{KVW{1'b0}}, w_cap_inc, 1'b0};
                            end else begin
                                r_mem[r_addr] <= {w_ch_kv, w_cap_inc, 1'b1};
                                r_dn_start    <= 1'b1;
                                r_dn_op       <= OP_DEQ;
                                r_dn_addr     <= {r_addr, w_sel_r};
                                r_done        <= D_NEXT;
                            end
                        end
                        default: begin
                            if (w_enq_keep) begin
                                r_mem[r_addr] <= {r_kv, w_e_cap, 1'b1};
                            end else begin
                                r_mem[r_addr] <= {w_ch_kv, w_e_cap, 1'b1};
                                r_dn_start    <= 1'b1;
                                r_dn_op       <= OP_ENQ_DEQ;
                                r_dn_kv       <= r_kv;
                                r_dn_addr     <= {r_addr, w_sel_r};
                                r_done        <= D_NEXT;
                            end
                        end
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dn_start = r_dn_start;
    assign dn_op    = r_dn_op;
    assign dn_kv    = r_dn_kv;
    assign dn_addr  = r_dn_addr;
    assign done     = r_done;
    assign busy     = r_busy;
    assign ovf      = r_ovf;

`ifdef PHEAP_LEVEL_OCC_EN
    logic [AW+1:0] r_occ;
    logic          w_occ_inc, w_occ_dec;

    // A DEQ on an already empty entry leaves the count alone.
    assign w_occ_inc = (r_state == S_EXEC) && (r_op == OP_LEQ) && !w_e_act;
    assign w_occ_dec = (r_state == S_EXEC) && (r_op == OP_DEQ) && !w_any_act && w_e_act;

    always_ff @(posedge clk) begin
        if (rst)            r_occ <= '0;
        else if (w_occ_inc) r_occ <= r_occ + (AW+2)'(1);
        else if (w_occ_dec) r_occ <= r_occ - (AW+2)'(1);
    end

    assign occ = r_occ;
`endif
endmodule
